// File: rtl/regfile_bist.sv
// regfile_bist: two-pass march initiator for the register file.
// Pass 0 writes P(i) = seed_q + i to every address and reads it back on both
// read ports; pass 1 does the same with ~P(i). Mismatches are counted
// (saturating) and the first failing address is captured.
//
// Handshake: start is a level sampled only while idle (IDLE or DONE); the
// edge that sees it launches a run and raises busy. busy stays high for the
// whole march, then drops as done rises. done holds until the next start or
// reset, and err_count/fail_addr/pass are final whenever done is high.
module regfile_bist #(
  parameter int REG_W   = 5,
  parameter int MEM_W   = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MEM_W-1:0] seed,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output logic             we,
  output logic [MEM_W-1:0] indata,
  input  logic [MEM_W-1:0] rv1,
  input  logic [MEM_W-1:0] rv2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [REG_W+1:0] err_count,
  output logic [REG_W-1:0] fail_addr,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

  localparam logic [REG_W-1:0] LAST    = '1;
  localparam logic [REG_W+1:0] ERR_MAX = '1;

  state_t           state, state_n;
  logic [REG_W-1:0] idx, idx_n;
  logic [MEM_W-1:0] seed_q, seed_n;
  logic             launch;

  logic [REG_W-1:0] rs1_n, rs2_n, rd_n;
  logic             we_n;
  logic [MEM_W-1:0] indata_n, pat_n;

  logic             in_rd, inv, miss1, miss2;
  logic [REG_W+2:0] err_sum;
  logic [REG_W+1:0] err_sat;

  // Expected read value of an address in the current pass.
  function automatic logic [MEM_W-1:0] exp_val(input logic [MEM_W-1:0] base,
                                                input logic [REG_W-1:0] a,
                                                input logic             flip);
    logic [MEM_W-1:0] p;
    p = base + MEM_W'(a);
    if (ZERO_R0 && (a == '0)) p = '0;
    else if (flip)            p = ~p;
    return p;
  endfunction

  assign busy      = (state != IDLE) && (state != DONE);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state;

  // Next-state logic; launch marks the start-sampling edge.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin state_n = WR0; launch = 1'b1; end
      WR0:        if (idx == LAST) state_n = RD0;
      RD0:        if (idx == LAST) state_n = WR1;
      WR1:        if (idx == LAST) state_n = RD1;
      RD1:        if (idx == LAST) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  // Index/seed update and next values of the registered regfile bus.
  always_comb begin
    idx_n    = (state_n != state || !busy) ? '0 : idx + REG_W'(1);
    seed_n   = launch ? seed : seed_q;
    pat_n    = seed_n + MEM_W'(idx_n);
    rs1_n    = '0;
    rs2_n    = '0;
    rd_n     = '0;
    we_n     = 1'b0;
    indata_n = '0;
    case (state_n)
      WR0: begin rd_n = idx_n; we_n = 1'b1; indata_n = pat_n;  end
      WR1: begin rd_n = idx_n; we_n = 1'b1; indata_n = ~pat_n; end
      RD0, RD1: begin rs1_n = idx_n; rs2_n = LAST - idx_n; end
      default: ;
    endcase
  end

  // Read-port compare against the current addresses and saturating add.
  always_comb begin
    in_rd   = (state == RD0) || (state == RD1);
    inv     = (state == RD1);
    miss1   = in_rd && (rv1 != exp_val(seed_q, rs1, inv));
    miss2   = in_rd && (rv2 != exp_val(seed_q, rs2, inv));
    err_sum = {1'b0, err_count} + (REG_W+3)'(miss1) + (REG_W+3)'(miss2);
    err_sat = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[REG_W+1:0];
  end

  // FSM state, index, latched seed and registered regfile bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      seed_q <= '0;
      rs1    <= '0;
      rs2    <= '0;
      rd     <= '0;
      we     <= 1'b0;
      indata <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      seed_q <= seed_n;
      rs1    <= rs1_n;
      rs2    <= rs2_n;
      rd     <= rd_n;
      we     <= we_n;
      indata <= indata_n;
    end
  end

  // Result tracking: cleared on launch, first mismatch wins fail_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else if (launch) begin
      done      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      if (miss1 || miss2) begin
        err_count <= err_sat;
        if (err_count == '0) fail_addr <= miss1 ? rs1 : rs2;
      end
      if (state == RD1 && state_n == DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: drives directed march runs against behavioural regfile
// models and checks each run's result in a scoreboard when done rises.
module tb_regfile_bist;

  localparam int REG_W = 5;
  localparam int MEM_W = 32;
  localparam int W     = 29;  // {pass, err[6:0], fail[4:0], cycles[7:0], writes[7:0]}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (ZERO_R0=1) ----------------
  logic             start0 = 1'b0;
  logic [MEM_W-1:0] seed0  = '0;
  logic [REG_W-1:0] rs1_0, rs2_0, rd0, fail0;
  logic             we0, busy0, done0, pass0;
  logic [MEM_W-1:0] indata0, rv1_0, rv2_0;
  logic [REG_W+1:0] err0;
  logic [2:0]       st0;

  regfile_bist #(.REG_W(REG_W), .MEM_W(MEM_W), .ZERO_R0(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0),
    .rs1(rs1_0), .rs2(rs2_0), .rd(rd0), .we(we0), .indata(indata0),
    .rv1(rv1_0), .rv2(rv2_0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_addr(fail0), .dbg_state(st0)
  );

  // ---------------- DUT 1 (ZERO_R0=0) ----------------
  logic             start1 = 1'b0;
  logic [MEM_W-1:0] seed1  = '0;
  logic [REG_W-1:0] rs1_1, rs2_1, rd1, fail1;
  logic             we1, busy1, done1, pass1;
  logic [MEM_W-1:0] indata1, rv1_1, rv2_1;
  logic [REG_W+1:0] err1;
  logic [2:0]       st1;

  regfile_bist #(.REG_W(REG_W), .MEM_W(MEM_W), .ZERO_R0(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1),
    .rs1(rs1_1), .rs2(rs2_1), .rd(rd1), .we(we1), .indata(indata1),
    .rv1(rv1_1), .rv2(rv2_1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_addr(fail1), .dbg_state(st1)
  );

  // ---------------- regfile models (r0 hardwired zero) ----------------
  // mode: 0 ideal, 1 reg 5 bit 3 stuck-at-0, 2 every read returns DEADBEEF
  int          mode = 0;
  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];

  function automatic logic [31:0] model_rd(input logic [31:0] word,
                                           input logic [4:0] a, input int m);
    if (m == 2) return 32'hDEADBEEF;
    if (a == 5'd0) return 32'h0;
    if (m == 1 && a == 5'd5) return word & ~32'h8;
    return word;
  endfunction

  always @(posedge clk) begin
    if (we0 && rd0 != 5'd0) mem0[rd0] <= indata0;
    if (we1 && rd1 != 5'd0) mem1[rd1] <= indata1;
  end

  assign rv1_0 = model_rd(mem0[rs1_0], rs1_0, mode);
  assign rv2_0 = model_rd(mem0[rs2_0], rs2_0, mode);
  assign rv1_1 = model_rd(mem1[rs1_1], rs1_1, 0);
  assign rv2_1 = model_rd(mem1[rs2_1], rs2_1, 0);

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic p, input logic [6:0] e,
                                      input logic [4:0] f, input logic [7:0] c,
                                      input logic [7:0] w);
    return {p, e, f, c, w};
  endfunction

  // ---------------- monitored DUT select ----------------
  logic             sel = 1'b0;
  logic             m_done, m_busy, m_we, m_pass;
  logic [REG_W+1:0] m_err;
  logic [REG_W-1:0] m_fail;
  assign m_done = sel ? done1 : done0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_we   = sel ? we1   : we0;
  assign m_pass = sel ? pass1 : pass0;
  assign m_err  = sel ? err1  : err0;
  assign m_fail = sel ? fail1 : fail0;

  // ---------------- scoreboard monitor ----------------
  int   cyc_cnt = 0;
  int   we_cnt  = 0;
  logic done_d  = 1'b0;

  // Count busy/write cycles and compare the run result when done rises.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      cyc_cnt = 0;
      we_cnt  = 0;
      done_d  = 1'b0;
    end else begin
      if (m_busy) cyc_cnt++;
      if (m_we)   we_cnt++;
      if (m_done && !done_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("pass",      64'(m_pass),  64'(e[28]));
          check("err_count", 64'(m_err),   64'(e[27:21]));
          check("fail_addr", 64'(m_fail),  64'(e[20:16]));
          check("busy_cyc",  64'(cyc_cnt), 64'(e[15:8]));
          check("we_cyc",    64'(we_cnt),  64'(e[7:0]));
        end
        cyc_cnt = 0;
        we_cnt  = 0;
      end
      done_d = m_done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input bit which, input logic [31:0] s);
    @(negedge clk);
    sel = which;
    if (which) begin seed1 = s; start1 = 1'b1; end
    else       begin seed0 = s; start0 = 1'b1; end
    @(posedge clk);
    #1;
    check("launch_done_clr", 64'(which ? done1 : done0), 64'd0);
    check("launch_busy",     64'(which ? busy1 : busy0), 64'd1);
    check("launch_err_clr",  64'(which ? err1 : err0),   64'd0);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!m_done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!m_done) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"},   64'({rs1_0, rs2_0, rd0}), 64'd0);
    check({tag, "_we"},     64'(we0), 64'd0);
    check({tag, "_indata"}, 64'(indata0), 64'd0);
    check({tag, "_status"}, 64'({busy0, done0, pass0, err0, fail0}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 32; k++) begin mem0[k] = '0; mem1[k] = '0; end
    #1;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ideal model, seed 0
    mode = 0;
    exp_q.push_back(mk(1'b1, 7'd0, 5'd0, 8'd128, 8'd64));
    launch(1'b0, 32'h0);
    wait_done();
    check("ideal_done_held", 64'(done0), 64'd1);

    // restart from DONE, reg 5 bit 3 stuck-at-0
    mode = 1;
    exp_q.push_back(mk(1'b0, 7'd2, 5'd5, 8'd128, 8'd64));
    launch(1'b0, 32'h0);
    wait_done();

    // wrap-around seed, ideal model
    mode = 0;
    exp_q.push_back(mk(1'b1, 7'd0, 5'd0, 8'd128, 8'd64));
    launch(1'b0, 32'hFFFF_FFF0);
    repeat (15) @(negedge clk);
    check("wrap_rd15",     64'({we0, rd0}), 64'({1'b1, 5'd15}));
    check("wrap_data15",   64'(indata0), 64'hFFFF_FFFF);
    @(negedge clk);
    check("wrap_rd16",     64'({we0, rd0}), 64'({1'b1, 5'd16}));
    check("wrap_data16",   64'(indata0), 64'h0000_0000);
    wait_done();

    // ZERO_R0=0 instance against an r0-hardwired model
    exp_q.push_back(mk(1'b0, 7'd2, 5'd0, 8'd128, 8'd64));
    launch(1'b1, 32'h0);
    wait_done();

    // asynchronous reset mid-run, then a clean run with start poked while busy
    mode = 0;
    launch(1'b0, 32'h0);
    repeat (39) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrun_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(1'b1, 7'd0, 5'd0, 8'd128, 8'd64));
    launch(1'b0, 32'h0);
    repeat (50) @(negedge clk);
    start0 = 1'b1;
    repeat (3) @(negedge clk);
    start0 = 1'b0;
    wait_done();

    // every read wrong on both ports: saturate at 127
    mode = 2;
    exp_q.push_back(mk(1'b0, 7'd127, 5'd0, 8'd128, 8'd64));
    launch(1'b0, 32'h0);
    wait_done();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Self-checking initiator for the register file: it drives the regfile's write and dual-read ports (rd/we/indata, rs1/rs2) and checks the returned rv1/rv2. It replaces manual VIO-driven poking with an automatic two-pass march. It sits between the regfile and the VIO/status logic in the top level, and shares the regfile clock. It reports pass/fail, an error count and the first failing address.

## Interface
- REG_W, 5: register address width; depth N = 2^REG_W (matches `reg_w`).
- MEM_W, 32: data width (matches `mem_w`).
- ZERO_R0, 1: 1 = register 0 is hardwired zero, so the expected read of address 0 is 0 in both passes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  level-sampled in IDLE/DONE; launches a run.
- seed  in  MEM_W  pattern base; sampled on the start edge and held internally.
- rs1, rs2, rd  out  REG_W  registered regfile addresses.
- we  out  1  registered regfile write enable.
- indata  out  MEM_W  registered regfile write data.
- rv1, rv2  in  MEM_W  regfile read data; combinational in address.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start or reset.
- pass  out  1  done && err_count==0.
- err_count  out  REG_W+2  mismatches, saturating at all-ones.
- fail_addr  out  REG_W  address of the first mismatch; 0 if none.

## Operation
- Pattern: P(i) = (seed_q + i) mod 2^MEM_W, with i zero-extended. Pass 0 expects P(i), pass 1 expects ~P(i).
- Expected value of address 0 is 0 when ZERO_R0=1.
- States: IDLE, WR0, RD0, WR1, RD1, DONE. Index counter i is REG_W bits, cleared on every state change.
- IDLE/DONE with start=1: latch seed, clear err_count/fail_addr/done, go to WR0.
- WRx: rd=i, we=1, indata=P(i) (WR0) or ~P(i) (WR1). At i=N-1 go to RDx.
- RDx: rs1=i, rs2=N-1-i. At i=N-1, RD0 goes to WR1 and RD1 goes to DONE.
- Outside WR states: we=0, rd=0, indata=0. Outside RD states: rs1=rs2=0.
- Compare: on every RD-state edge, rv1 is checked against exp(rs1) and rv2 against exp(rs2). Each mismatching port adds 1 to err_count, so one cycle can add 0, 1 or 2.
- The first mismatch of the run loads fail_addr. If both ports fail in that cycle, rs1 takes priority.
- start while busy is ignored.
- Reset, at any time including mid-run: state IDLE. All outputs 0 (rs1, rs2, rd, we, indata, busy, done, pass, err_count, fail_addr). seed_q is cleared.

## Timing
- Edge E0 samples start. WR0 outputs are visible from E0 to E32; RD0 from E32 to E64; WR1 from E64 to E96; RD1 from E96 to E128.
- busy=1 from E0 through E128; busy=0 and done=1 after E128.
- A run is 4N = 128 cycles at the defaults.
- Regfile write of address i commits on the edge ending the cycle in which rd=i.
- Reads have zero latency: rv is sampled on the edge that ends the address cycle. The last compare occurs at E128, so err_count and pass are final when done rises.
- The first pass-0 read is 32 edges after its write. Write-to-read hazards inside the regfile are not exercised.
- Restart from DONE: start at Ek clears done at Ek and begins WR0 immediately.

## Test plan
- Ideal regfile model (r0 hardwired), seed=0 -> done at E128, pass=1, err_count=0, we high exactly 64 cycles.
- Model with reg 5 bit 3 stuck-at-0, seed=0 -> pass 0 clean (P(5)=5). Pass 1 fails on rs1 at i=5 and on rs2 at i=26, so err_count=2, fail_addr=5, pass=0.
- Wrap-around, seed=32'hFFFFFFF0, ideal model -> indata in WR0 is 0xFFFFFFFF at i=15 and 0x00000000 at i=16, with no carry beyond MEM_W; pass=1.
- ZERO_R0=0 against an r0-hardwired model, seed=0 -> pass 1 mismatches at rs1 i=0 and rs2 i=31. Result: err_count=2, fail_addr=0.
- rst_n pulsed low at E40 -> all outputs 0 asynchronously. start at E40+5 runs a full clean 128-cycle sequence. start re-asserted while busy has no effect on the cycle count.
- Model with all reads returning 0xDEADBEEF -> 2 errors per RD cycle, err_count saturates at 127 (default widths) and fail_addr=0.
